serial_frame_rx: RTL and testbench

//  Downstream consumer of the shift-register serial output (so).

---
 rtl/serial_frame_rx.sv | 157 +++++++++++++++
 tb/tb_serial_frame_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(1) + LEN data bits MSB-first + [even parity] + stop(0),
// delivered on a valid/ready port. Optional parity via `define SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
  parameter int LEN = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           si,
  input  logic           en,
  output logic [LEN-1:0] dout,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic           busy,
  output logic           frame_err,
  output logic           parity_err,
  output logic           overrun
);

  localparam int CW = $clog2(LEN + 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, STOP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LEN-1:0]  shreg_q, shreg_d;
  logic [LEN-1:0]  dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            parity_bad;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
`endif

  // NOTE: every variable gets a default before the case statement; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_bad   = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (en && si) begin
          state_d = DATA;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end

      DATA: begin
        if (en) begin
          shreg_d = {shreg_q[LEN-2:0], si};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(LEN - 1)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef SERIAL_FRAME_RX_PARITY_EN
      PAR: begin
        if (en) begin
          par_d   = si;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (en) begin
          frame_err_d = si;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          parity_bad   = ^{shreg_q, par_q};
          parity_err_d = parity_bad;
`endif
          // A slot being drained on this same edge counts as free.
          if (!si && !parity_bad) begin
            if (!dout_valid_q || dout_ready) begin
              dout_d       = shreg_q;
              dout_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (LEN=16): directed frames push expected words
// and error events; a negedge monitor pops and compares whenever the DUT presents them.
module tb_serial_frame_rx;
  localparam int LEN = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           si;
  logic           en;
  logic [LEN-1:0] dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           busy;
  logic           frame_err;
  logic           parity_err;
  logic           overrun;

  int total = 0;
  int bad   = 0;

  logic [LEN-1:0] word_q[$];
  logic [2:0]     ev_q[$];   // {frame_err, parity_err, overrun}

  serial_frame_rx #(.LEN(LEN)) dut (
    .clk(clk), .rst(rst), .si(si), .en(en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares presented words/events against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && dout_ready) begin
        if (word_q.size() == 0) check("spurious_word_qsize", word_q.size(), 1);
        else                    check("dout_word", dout, word_q.pop_front());
      end
      if ({frame_err, parity_err, overrun} != 3'b000) begin
        if (ev_q.size() == 0) check("spurious_event_qsize", ev_q.size(), 1);
        else                  check("error_event", {frame_err, parity_err, overrun}, ev_q.pop_front());
      end
    end
  end

  task automatic send_bit(input logic b, input bit toggle);
    si = b;
    en = 1'b1;
    @(posedge clk); #1;
    if (toggle) begin
      en = 1'b0;
      si = ~b;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [LEN-1:0] w, input logic stop_b, input logic par_b,
                            input bit toggle, input bit exp_word, input logic [2:0] exp_ev);
    if (exp_word) word_q.push_back(w);
    if (exp_ev != 3'b000) ev_q.push_back(exp_ev);
    send_bit(1'b1, toggle);
    for (int i = LEN - 1; i >= 0; i--) send_bit(w[i], toggle);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_bit(par_b, toggle);
`endif
    check("busy_before_stop", busy, 1);
    send_bit(stop_b, toggle);
    si = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; si = 1'b0; en = 1'b1; dout_ready = 1'b0;
    #2;
    check("reset_dout", dout, 0);
    check("reset_outputs", {dout_valid, busy, frame_err, parity_err, overrun}, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_line_busy", busy, 0);

    // 1: good frame, consumer ready, valid for exactly one cycle
    dout_ready = 1'b1;
    send_frame(16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    check("t1_valid_set", dout_valid, 1);
    check("t1_dout", dout, 16'hFF00);
    @(posedge clk); #1;
    check("t1_valid_clear", dout_valid, 0);

    // 2: output full -> second word overruns, dout held
    dout_ready = 1'b0;
    send_frame(16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    send_frame(16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
    check("t2_overrun_pulse", overrun, 1);
    check("t2_dout_held", dout, 16'hA5A5);
    check("t2_valid_held", dout_valid, 1);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_valid_drop", dout_valid, 0);
    check("t2_overrun_gone", overrun, 0);

    // 3: stop bit 1 -> frame error, word dropped
    send_frame(16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100);
    check("t3_valid", dout_valid, 0);
    check("t3_busy", busy, 0);
    check("t3_frame_err", frame_err, 1);

    // 4: en toggling each cycle
    dout_ready = 1'b0;
    send_frame(16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    check("t4_dout", dout, 16'hF0F0);
    check("t4_valid", dout_valid, 1);
    dout_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_valid_drop", dout_valid, 0);

    // 5: reset after 7 data bits, then a clean frame
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    check("t5_busy_mid", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_reset_dout", dout, 0);
    check("t5_reset_outputs", {dout_valid, busy, frame_err, parity_err, overrun}, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    si = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    check("t5_idle_after_reset", busy, 0);
    send_frame(16'h8001, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    check("t5_dout", dout, 16'h8001);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // 6: parity good then parity bad
    send_frame(16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    check("t6_good_dout", dout, 16'h0001);
    send_frame(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    check("t6_parity_err", parity_err, 1);
    check("t6_valid", dout_valid, 0);
`else
    check("parity_err_tied", parity_err, 0);
`endif

    repeat (3) @(posedge clk); #1;
    check("word_queue_drained", word_q.size(), 0);
    check("event_queue_drained", ev_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
